// File: rtl/fp_vec_arbiter.sv
// Vector-atomic round-robin arbiter sharing one cnt1 popcount stage between
// REQ_NO fingerprint streams; a grant always covers one whole vector.
module fp_vec_arbiter #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int REQ_NO       = 4,
  localparam int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  localparam int ID_WIDTH      = ($clog2(REQ_NO) > 1) ? $clog2(REQ_NO) : 1,
  localparam int BEAT_WIDTH    = $clog2(SUB_VECTOR_NO) + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [REQ_NO*BUS_WIDTH-1:0] i_Vector,
  input  logic [REQ_NO-1:0]           i_Valid,
  output logic [REQ_NO-1:0]           o_Ready,
  output logic [BUS_WIDTH-1:0]        o_SubVector,
  output logic                        o_Valid,
  output logic [ID_WIDTH-1:0]         o_Id,
  output logic                        o_Last,
  input  logic                        i_Ready,
  output logic                        o_Busy
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam int unsigned REQ_U = REQ_NO;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_gnt;
  logic [ID_WIDTH-1:0]   r_last;
  logic [BEAT_WIDTH-1:0] r_beat;

  logic                  w_grant;
  logic                  w_xfer;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH-1:0]   w_winner;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    w_found  = 1'b0;
    w_cand   = '0;
    w_winner = r_gnt;
    for (int unsigned i = 1; i <= REQ_U; i++) begin
      w_cand = ID_WIDTH'((32'(r_last) + i) % REQ_U);
      if (!w_found && i_Valid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant     = (r_state == ST_GRANT);
    o_SubVector = i_Vector[int'(r_gnt)*BUS_WIDTH +: BUS_WIDTH];
    o_Valid     = w_grant && i_Valid[r_gnt];
    o_Ready     = '0;
    if (w_grant) begin
      o_Ready[r_gnt] = i_Ready;
    end
    o_Id   = r_gnt;
    o_Last = w_grant && (r_beat == BEAT_WIDTH'(SUB_VECTOR_NO - 1));
    o_Busy = w_grant;
    w_xfer = o_Valid && i_Ready;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= ID_WIDTH'(REQ_NO - 1);
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_winner;
            r_beat  <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Grant is held until the last beat transfers; valid gaps just stall.
          if (w_xfer) begin
            r_beat <= r_beat + 1'b1;
            if (o_Last) begin
              r_last  <= r_gnt;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vec_arbiter.sv
// Self-checking bench for fp_vec_arbiter: source FIFO models, a per-requester
// payload scoreboard, an arbitration vector table and multi-cycle sequences.
module tb_fp_vec_arbiter;
  localparam int BW = 128;
  localparam int RQ = 4;
  localparam int SV = 8;
  localparam logic [BW-1:0] P0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [BW-1:0] P1 = 128'hB1B1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic [RQ*BW-1:0] i_Vector;
  logic [RQ-1:0]    i_Valid;
  logic [RQ-1:0]    o_Ready;
  logic [BW-1:0]    o_SubVector;
  logic             o_Valid;
  logic [1:0]       o_Id;
  logic             o_Last;
  logic             i_Ready;
  logic             o_Busy;

  logic [2*BW-1:0]  v2_Vector;
  logic [1:0]       v2_iValid;
  logic [1:0]       v2_oReady;
  logic [BW-1:0]    v2_Sub;
  logic             v2_oValid;
  logic [0:0]       v2_Id;
  logic             v2_Last;
  logic             v2_iReady;
  logic             v2_Busy;

  fp_vec_arbiter #(.BUS_WIDTH(BW), .VECTOR_WIDTH(920), .REQ_NO(RQ)) u_dut (
    .clk(clk), .rstn(rstn), .i_Vector(i_Vector), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .o_SubVector(o_SubVector), .o_Valid(o_Valid),
    .o_Id(o_Id), .o_Last(o_Last), .i_Ready(i_Ready), .o_Busy(o_Busy));

  fp_vec_arbiter #(.BUS_WIDTH(BW), .VECTOR_WIDTH(128), .REQ_NO(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .i_Vector(v2_Vector), .i_Valid(v2_iValid),
    .o_Ready(v2_oReady), .o_SubVector(v2_Sub), .o_Valid(v2_oValid),
    .o_Id(v2_Id), .o_Last(v2_Last), .i_Ready(v2_iReady), .o_Busy(v2_Busy));

  typedef logic [BW-1:0] beat_t;
  typedef struct {
    int            prev;
    logic [RQ-1:0] mask;
    logic [1:0]    exp_gnt;
  } arb_vec_t;

  beat_t      src_q[RQ][$];
  beat_t      exp_q[RQ][$];
  logic [1:0] got_order[$];
  logic [RQ-1:0] en;
  arb_vec_t   tbl[8];

  int n_checks = 0;
  int n_err    = 0;
  int in_vec   = 0;
  int n_xfer   = 0;
  int n_vec_done = 0;
  int seq      = 0;
  int rdy_cnt  = 0;
  int t2_c     = 0;
  logic [1:0] cur_id = '0;
  bit prev_last = 0, prev_req = 0, prev_rst = 0;
  bit rdy_rand = 0, rdy_on = 0, t2_on = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < RQ; k++) begin
      if (src_q[k].size() > 0) begin
        i_Vector[k*BW +: BW] = src_q[k][0];
        i_Valid[k]           = en[k];
      end else begin
        i_Vector[k*BW +: BW] = '0;
        i_Valid[k]           = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    int    exp_id;
    if (prev_rst) begin
      check("reset_outputs", {o_Busy, o_Valid, o_Ready, o_Last, o_Id}, '0);
      check("reset_outputs2", {v2_Busy, v2_oValid, v2_oReady, v2_Last}, '0);
    end
    if (!rstn) begin
      prev_rst = 1; in_vec = 0; prev_last = 0; prev_req = 0;
      return;
    end
    prev_rst = 0;
    if (prev_last) check("bubble", o_Busy, 1'b0);
    if (prev_req)  check("arb_latency", o_Busy, 1'b1);
    if (!o_Busy) begin
      check("idle_outputs", {o_Valid, o_Ready, o_Last}, '0);
    end else begin
      check("ready_route", o_Ready, RQ'(i_Ready) << o_Id);
      check("valid_route", o_Valid, i_Valid[o_Id]);
      if (in_vec != 0) check("id_stable", o_Id, cur_id);
    end
    prev_req  = !o_Busy && (i_Valid != '0);
    prev_last = 0;
    if (o_Valid && i_Ready) begin
      if (in_vec == 0) begin
        cur_id = o_Id;
        got_order.push_back(o_Id);
      end
      if (exp_q[o_Id].size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_beat: got id %0d data %0h expected no beat", o_Id, o_SubVector);
      end else begin
        e = exp_q[o_Id].pop_front();
        check("payload", o_SubVector, e);
      end
      check("last_flag", o_Last, (in_vec == SV - 1));
      if (src_q[o_Id].size() > 0) void'(src_q[o_Id].pop_front());
      n_xfer++;
      if (in_vec == SV - 1) begin
        in_vec = 0; n_vec_done++; prev_last = 1;
      end else begin
        in_vec++;
      end
    end
    if (t2_on) begin
      check("r2_valid", v2_oValid, t2_c[0]);
      if (t2_c % 2 == 1) begin
        exp_id = ((t2_c - 1) / 2) % 2;
        check("r2_id", v2_Id, exp_id);
        check("r2_last", v2_Last, 1'b1);
        check("r2_data", v2_Sub, (exp_id == 1) ? P1 : P0);
      end
      t2_c++;
    end
  endtask

  task automatic tick();
    apply_inputs();
    if (rdy_rand) begin
      if (rdy_cnt <= 0) begin
        rdy_on  = !rdy_on;
        rdy_cnt = rdy_on ? int'($urandom_range(10, 1)) : int'($urandom_range(5, 1));
      end
      rdy_cnt--;
      i_Ready = rdy_on;
    end else begin
      i_Ready = 1'b1;
    end
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int nvec);
    beat_t d;
    for (int b = 0; b < nvec * SV; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[BW-1 -: 8]  = 8'(k);
      d[BW-9 -: 16] = 16'(seq);
      seq++;
      src_q[k].push_back(d);
      exp_q[k].push_back(d);
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < RQ; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    en = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_all();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic wait_started(input int n, input string name);
    int target = got_order.size() + n;
    int budget = 3000;
    while (got_order.size() < target && budget > 0) begin tick(); budget--; end
    if (got_order.size() < target) begin
      n_checks++; n_err++;
      $display("FAIL timeout_%s: got %0d grants expected %0d", name, got_order.size(), target);
    end
  endtask

  task automatic wait_done(input int n, input string name);
    int target = n_vec_done + n;
    int budget = 3000;
    while (n_vec_done < target && budget > 0) begin tick(); budget--; end
    if (n_vec_done < target) begin
      n_checks++; n_err++;
      $display("FAIL timeout_%s: got %0d vectors expected %0d", name, n_vec_done, target);
    end
  endtask

  task automatic wait_beat(input int b, input string name);
    int budget = 3000;
    while (in_vec != b && budget > 0) begin tick(); budget--; end
    if (in_vec != b) begin
      n_checks++; n_err++;
      $display("FAIL timeout_%s: got beat %0d expected %0d", name, in_vec, b);
    end
  endtask

  initial begin
    int base;
    int start;
    logic [1:0] exp4[5];

    tbl[0] = '{0, 4'b1111, 2'd1};
    tbl[1] = '{1, 4'b1001, 2'd3};
    tbl[2] = '{2, 4'b0110, 2'd1};
    tbl[3] = '{3, 4'b1100, 2'd2};
    tbl[4] = '{0, 4'b0001, 2'd0};
    tbl[5] = '{2, 4'b1000, 2'd3};
    tbl[6] = '{3, 4'b0011, 2'd0};
    tbl[7] = '{1, 4'b0101, 2'd2};

    rstn      = 1'b0;
    en        = '0;
    i_Vector  = '0;
    i_Valid   = '0;
    i_Ready   = 1'b1;
    v2_Vector = {P1, P0};
    v2_iValid = 2'b11;
    v2_iReady = 1'b1;

    // Rotating-priority table: previous winner p, then simultaneous requests.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      load(tbl[r].prev, 1);
      en = RQ'(1) << tbl[r].prev;
      wait_done(1, $sformatf("tbl%0d_pre", r));
      for (int k = 0; k < RQ; k++) if (tbl[r].mask[k]) load(k, 1);
      en = tbl[r].mask;
      wait_started(1, $sformatf("tbl%0d", r));
      check($sformatf("arb_tbl%0d", r), got_order[got_order.size()-1], tbl[r].exp_gnt);
    end

    // Single requester 2, continuous: 9 cycles per vector.
    do_reset();
    load(2, 3);
    en = 4'b0100;
    start = n_xfer;
    base  = got_order.size();
    repeat (27) tick();
    check("single_xfers", n_xfer - start, 24);
    for (int i = 0; i < 3; i++) check("single_id", got_order[base+i], 2'd2);
    check("single_drained", exp_q[2].size(), 0);

    // All four requesting from reset: strict rotation 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < RQ; k++) load(k, 2);
    en = 4'b1111;
    base = got_order.size();
    exp4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    wait_done(5, "all4");
    for (int i = 0; i < 5; i++) check($sformatf("all4_order%0d", i), got_order[base+i], exp4[i]);

    // Random backpressure with requesters 1 and 3.
    do_reset();
    rdy_rand = 1;
    load(1, 3);
    load(3, 3);
    en = 4'b1010;
    base = got_order.size();
    wait_done(6, "bp");
    rdy_rand = 0;
    for (int i = 0; i < 6; i++) check($sformatf("bp_order%0d", i), got_order[base+i], (i % 2 == 0) ? 2'd1 : 2'd3);
    check("bp_drained", exp_q[1].size() + exp_q[3].size(), 0);

    // Requester 1 stalls mid-vector while 0 waits; grant must be held.
    do_reset();
    load(1, 1);
    en = 4'b0010;
    wait_started(1, "gap_grant");
    load(0, 1);
    en = 4'b0011;
    wait_beat(4, "gap_beat");
    en[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      apply_inputs();
      #1;
      check("gap_valid", o_Valid, 1'b0);
      check("gap_hold", {o_Busy, o_Id}, {1'b1, 2'd1});
      check("gap_ready0", o_Ready[0], 1'b0);
      tick();
    end
    en[1] = 1'b1;
    base = got_order.size();
    wait_done(2, "gap_done");
    check("gap_next_grant", got_order[base], 2'd0);
    check("gap_drained", exp_q[1].size() + exp_q[0].size(), 0);

    // Reset during beat 5 of requester 3 after requester 0 last won.
    do_reset();
    load(0, 1);
    en = 4'b0001;
    wait_done(1, "rst_pre");
    load(3, 1);
    en = 4'b1001;
    wait_beat(5, "rst_beat");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    clear_all();
    load(0, 1);
    load(3, 1);
    en = 4'b1001;
    base = got_order.size();
    wait_started(1, "rst_post");
    check("rst_first_grant", got_order[base], 2'd0);

    // Two requesters, one beat per vector.
    do_reset();
    t2_on = 1;
    t2_c  = 0;
    repeat (8) tick();
    t2_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
